// File: rtl/echo_pkg.sv
// Shared types, constants and the saturating adder for the echo_delay stage.
package echo_pkg;

  // Default sample width: 24-bit two's complement audio from the codec.
  localparam int DATA_W = 24;

  // Clamp limits for a DATA_W-bit signed sample.
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Control states of the per-sample sequence.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CALC = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Signed add carried out one bit wider than a sample, then clamped.
  // If the two top bits of the wide sum disagree, the result overflowed.
  // The sign bit of the wide sum then tells which rail to clamp to.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    logic [DATA_W-1:0] res;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      res = sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      res = sum[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Delay-line storage for echo_delay.
// Simple dual-port RAM with one write port and one synchronous read port.
// The contents are deliberately left without a reset, so the block-RAM
// template is preserved and the array maps onto M10K.
module echo_ram #(
  parameter int DATA_W = echo_pkg::DATA_W,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store one sample when the core commits a result.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered read, so the data arrives one clock after the address.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_delay.sv
// Single-channel feedback echo stage between the codec read and write paths.
// Each accepted sample is mixed with an attenuated copy of the output from
// 2^DEPTH_LOG2 samples earlier. The mix is saturated, then written back to
// the circular buffer and presented on the codec write handshake.
module echo_delay
  import echo_pkg::*;
#(
  parameter int DATA_W      = echo_pkg::DATA_W,
  parameter int DEPTH_LOG2  = 14,
  parameter int DECAY_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t r_state;
  state_t w_nextState;

  logic [DATA_W-1:0]     r_x;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic                  r_primed;
  logic [DATA_W-1:0]     r_out;
  logic                  r_outValid;

  logic                     w_accept;
  logic                     w_calc;
  logic                     w_release;
  logic [DATA_W-1:0]        w_ramQ;
  logic signed [DATA_W-1:0] w_delayed;
  logic [DATA_W-1:0]        w_decayed;
  logic [DATA_W-1:0]        w_mix;
  logic [DATA_W-1:0]        w_y;
  logic [DATA_W-1:0]        w_wdata;
  logic                     w_ptrLast;

  // The read address is simply the write pointer.
  // The pointer only moves in CALC, so the RAM output is settled long before it is used.
  echo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_calc),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_ptr),
    .o_rdata (w_ramQ)
  );

  // Next-state logic and handshake strobes for the per-sample sequence.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_calc      = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_nextState = RD;
        end
      end
      RD: begin
        w_nextState = CALC;
      end
      CALC: begin
        w_calc      = 1'b1;
        w_nextState = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Echo arithmetic.
  // Until the buffer has wrapped once, its contents are stale, so the feedback is forced to zero.
  // In bypass, the dry sample passes straight through and zero is written back,
  // which flushes the tail as the pointer sweeps the buffer.
  always_comb begin
    w_delayed = r_primed ? $signed(w_ramQ) : '0;
    w_decayed = w_delayed >>> DECAY_SHIFT;
    w_mix     = sat_add(r_x, w_decayed);
    w_y       = enable ? w_mix : r_x;
    w_wdata   = enable ? w_mix : '0;
    w_ptrLast = &r_ptr;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the incoming sample when it is accepted from the codec.
  // The value is only consumed in CALC, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x <= in;
    end
  end

  // Circular write pointer and the primed flag, which is set by the first wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_primed <= 1'b0;
    end else if (w_calc) begin
      r_ptr <= r_ptr + 1'b1;
      if (w_ptrLast) begin
        r_primed <= 1'b1;
      end
    end
  end

  // Output register: loaded in CALC and held until the codec takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out      <= '0;
      r_outValid <= 1'b0;
    end else if (w_calc) begin
      r_out      <= w_y;
      r_outValid <= 1'b1;
    end else if (w_release) begin
      r_outValid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_outValid;

endmodule
